// File: rtl/vend_txn_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : vend_txn_sequencer
// Brief    : Vending transaction controller - coin credit, price/stock check,
//            dispense/change sequencing, inventory counters, refund paths.
// Revision : 1.0  initial release
// ============================================================================
module vend_txn_sequencer #(
    parameter int PRICE1     = 10,
    parameter int PRICE2     = 20,
    parameter int PRICE3     = 40,
    parameter int INIT_STOCK = 9,
    parameter int TIMEOUT    = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       coin_valid,
    input  logic [5:0] coin_value,
    input  logic       sel_valid,
    input  logic [1:0] product_sel,
    input  logic       cancel,
    input  logic       restock,
    output logic       dispense,
    output logic [1:0] dispensed_sel,
    output logic       change_valid,
    output logic [5:0] change,
    output logic [5:0] credit,
    output logic [3:0] prod1_count,
    output logic [3:0] prod2_count,
    output logic [3:0] prod3_count,
    output logic       coin_reject,
    output logic       err,
    output logic [1:0] err_code,
    output logic       busy
);

    localparam logic [2:0] c_st_idle     = 3'd0;
    localparam logic [2:0] c_st_collect  = 3'd1;
    localparam logic [2:0] c_st_check    = 3'd2;
    localparam logic [2:0] c_st_dispense = 3'd3;
    localparam logic [2:0] c_st_change   = 3'd4;
    localparam logic [2:0] c_st_refund   = 3'd5;

    localparam int              c_tw         = $clog2(TIMEOUT + 1);
    localparam logic [c_tw-1:0] c_timer_last = c_tw'(TIMEOUT - 1);
    localparam logic [c_tw-1:0] c_timer_one  = c_tw'(1);

    localparam logic [5:0] c_price1     = 6'(PRICE1);
    localparam logic [5:0] c_price2     = 6'(PRICE2);
    localparam logic [5:0] c_price3     = 6'(PRICE3);
    localparam logic [3:0] c_init_stock = 4'(INIT_STOCK);

    localparam logic [1:0] c_ec_invalid   = 2'b01;
    localparam logic [1:0] c_ec_sold_out  = 2'b10;
    localparam logic [1:0] c_ec_no_credit = 2'b11;

    logic [2:0]       r_state, w_state_nxt;
    logic [5:0]       r_credit, w_credit_nxt;
    logic [c_tw-1:0]  r_timer, w_timer_nxt;
    logic [1:0]       r_sel, w_sel_nxt;
    logic [2:0][3:0]  r_cnt, w_cnt_nxt;
    logic             r_coin_reject, w_coin_reject_nxt;
    logic             r_err, w_err_nxt;
    logic [1:0]       r_err_code, w_err_code_nxt;

    logic [6:0]       w_coin_sum;
    logic             w_coin_ok;
    logic [5:0]       w_price;
    logic [3:0]       w_sel_cnt;
    logic [5:0]       w_remain;

    // 7-bit sum so an overflowing coin is seen and refused instead of wrapping
    assign w_coin_sum = {1'b0, r_credit} + {1'b0, coin_value};
    assign w_coin_ok  = ((r_state == c_st_idle) || (r_state == c_st_collect)) &&
                        coin_valid && !sel_valid && !cancel && (w_coin_sum <= 7'd63);

    always_comb begin
        w_price   = 6'd0;
        w_sel_cnt = 4'd0;
        case (r_sel)
            2'd0: begin w_price = c_price1; w_sel_cnt = r_cnt[0]; end
            2'd1: begin w_price = c_price2; w_sel_cnt = r_cnt[1]; end
            2'd2: begin w_price = c_price3; w_sel_cnt = r_cnt[2]; end
            default: begin w_price = 6'd0; w_sel_cnt = 4'd0; end
        endcase
    end

    assign w_remain = r_credit - w_price;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_st_idle;
            r_credit      <= 6'd0;
            r_timer       <= '0;
            r_sel         <= 2'b00;
            r_cnt         <= {3{c_init_stock}};
            r_coin_reject <= 1'b0;
            r_err         <= 1'b0;
            r_err_code    <= 2'b00;
        end else begin
            r_state       <= w_state_nxt;
            r_credit      <= w_credit_nxt;
            r_timer       <= w_timer_nxt;
            r_sel         <= w_sel_nxt;
            r_cnt         <= w_cnt_nxt;
            r_coin_reject <= w_coin_reject_nxt;
            r_err         <= w_err_nxt;
            r_err_code    <= w_err_code_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_credit_nxt      = r_credit;
        w_timer_nxt       = r_timer;
        w_sel_nxt         = r_sel;
        w_cnt_nxt         = r_cnt;
        w_coin_reject_nxt = coin_valid && !w_coin_ok;
        w_err_nxt         = 1'b0;
        w_err_code_nxt    = 2'b00;

        case (r_state)
            c_st_idle: begin
                w_timer_nxt = '0;
                if (restock) begin
                    w_cnt_nxt = {3{c_init_stock}};
                end
                if (sel_valid && (r_credit == 6'd0)) begin
                    w_err_nxt      = 1'b1;
                    w_err_code_nxt = c_ec_no_credit;
                end else if (w_coin_ok) begin
                    w_credit_nxt = w_coin_sum[5:0];
                    w_state_nxt  = c_st_collect;
                end
            end

            c_st_collect: begin
                if (cancel) begin
                    w_state_nxt = c_st_refund;
                end else if (sel_valid) begin
                    w_sel_nxt   = product_sel;
                    w_state_nxt = c_st_check;
                end else if (w_coin_ok) begin
                    w_credit_nxt = w_coin_sum[5:0];
                    w_timer_nxt  = '0;
                end else if (r_timer == c_timer_last) begin
                    w_state_nxt = c_st_refund;
                end else begin
                    w_timer_nxt = r_timer + c_timer_one;
                end
            end

            c_st_check: begin
                if (r_sel == 2'b11) begin
                    w_err_code_nxt = c_ec_invalid;
                end else if (w_sel_cnt == 4'd0) begin
                    w_err_code_nxt = c_ec_sold_out;
                end else if (r_credit < w_price) begin
                    w_err_code_nxt = c_ec_no_credit;
                end
                if (w_err_code_nxt != 2'b00) begin
                    w_err_nxt   = 1'b1;
                    w_timer_nxt = '0;
                    w_state_nxt = c_st_collect;
                end else begin
                    w_state_nxt = c_st_dispense;
                end
            end

            c_st_dispense: begin
                // Saturating decrement; CHECK already guarantees a non-empty slot
                if (w_sel_cnt != 4'd0) begin
                    case (r_sel)
                        2'd0:    w_cnt_nxt[0] = w_sel_cnt - 4'd1;
                        2'd1:    w_cnt_nxt[1] = w_sel_cnt - 4'd1;
                        2'd2:    w_cnt_nxt[2] = w_sel_cnt - 4'd1;
                        default: w_cnt_nxt    = r_cnt;
                    endcase
                end
                w_credit_nxt = w_remain;
                w_state_nxt  = (w_remain != 6'd0) ? c_st_change : c_st_idle;
            end

            c_st_change, c_st_refund: begin
                w_credit_nxt = 6'd0;
                w_state_nxt  = c_st_idle;
            end

            default: begin
                w_state_nxt  = c_st_idle;
                w_credit_nxt = 6'd0;
                w_timer_nxt  = '0;
            end
        endcase
    end

    assign dispense      = (r_state == c_st_dispense);
    assign dispensed_sel = dispense ? r_sel : 2'b00;
    assign change_valid  = (r_state == c_st_change) || (r_state == c_st_refund);
    assign change        = change_valid ? r_credit : 6'd0;
    assign credit        = r_credit;
    assign prod1_count   = r_cnt[0];
    assign prod2_count   = r_cnt[1];
    assign prod3_count   = r_cnt[2];
    assign coin_reject   = r_coin_reject;
    assign err           = r_err;
    assign err_code      = r_err_code;
    assign busy          = (r_state == c_st_check) || (r_state == c_st_dispense) ||
                           (r_state == c_st_change) || (r_state == c_st_refund);

endmodule
`default_nettype wire

// File: tb/tb_vend_txn_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_vend_txn_sequencer
// Brief    : Directed and random stimulus against a transaction-level model.
// Revision : 1.0  initial release
// ============================================================================
module tb_vend_txn_sequencer;

    localparam int c_timeout   = 16;
    localparam int c_stock     = 9;
    localparam int c_rand_cycs = 4000;

    logic       clk = 1'b0;
    logic       rst, coin_valid, sel_valid, cancel, restock;
    logic [5:0] coin_value;
    logic [1:0] product_sel;
    logic       dispense, change_valid, coin_reject, err, busy;
    logic [1:0] dispensed_sel, err_code;
    logic [5:0] change, credit;
    logic [3:0] prod1_count, prod2_count, prod3_count;

    always #5 clk = ~clk;

    vend_txn_sequencer dut (
        .clk(clk), .rst(rst), .coin_valid(coin_valid), .coin_value(coin_value),
        .sel_valid(sel_valid), .product_sel(product_sel), .cancel(cancel),
        .restock(restock), .dispense(dispense), .dispensed_sel(dispensed_sel),
        .change_valid(change_valid), .change(change), .credit(credit),
        .prod1_count(prod1_count), .prod2_count(prod2_count), .prod3_count(prod3_count),
        .coin_reject(coin_reject), .err(err), .err_code(err_code), .busy(busy)
    );

    int checks = 0;
    int errors = 0;

    // Transaction model: a session holds credit; a decided transaction
    // (refund / failed check / purchase) plays out over fixed cycle offsets.
    int m_cyc = 0;
    int m_credit = 0;
    int m_cnt [3];
    int m_idle = 0;
    int m_ph = 0;      // 0 none, 1 refund, 2 failed check, 3 purchase
    int m_t0 = 0;
    int m_sel = 0;
    int m_ec = 0;
    bit m_session = 0;

    bit e_disp, e_cv, e_rej, e_err, e_busy;
    int e_dsel, e_chg, e_ec;

    function automatic int price(input int s);
        case (s)
            0: return 10;
            1: return 20;
            2: return 40;
            default: return 0;
        endcase
    endfunction

    task automatic start_refund();
        m_ph = 1; m_t0 = m_cyc; e_cv = 1; e_chg = m_credit;
    endtask

    task automatic model_step();
        int k;
        bit coin_ok;
        e_disp = 0; e_cv = 0; e_rej = 0; e_err = 0; e_dsel = 0; e_chg = 0; e_ec = 0;
        m_cyc++;
        if (rst) begin
            m_credit = 0; m_session = 0; m_idle = 0; m_ph = 0;
            for (int i = 0; i < 3; i++) m_cnt[i] = c_stock;
        end else if (m_ph != 0) begin
            k = m_cyc - m_t0;
            if (coin_valid) e_rej = 1;
            if (m_ph == 1) begin
                m_credit = 0; m_session = 0; m_ph = 0;
            end else if (m_ph == 2) begin
                e_err = 1; e_ec = m_ec; m_idle = 0; m_ph = 0;
            end else if (k == 1) begin
                e_disp = 1; e_dsel = m_sel;
            end else if (k == 2) begin
                m_credit = m_credit - price(m_sel);
                if (m_cnt[m_sel] > 0) m_cnt[m_sel]--;
                if (m_credit > 0) begin
                    e_cv = 1; e_chg = m_credit;
                end else begin
                    m_session = 0; m_ph = 0;
                end
            end else begin
                m_credit = 0; m_session = 0; m_ph = 0;
            end
        end else begin
            coin_ok = coin_valid && !sel_valid && !cancel && (m_credit + int'(coin_value) <= 63);
            if (coin_valid && !coin_ok) e_rej = 1;
            if (!m_session) begin
                if (restock) for (int i = 0; i < 3; i++) m_cnt[i] = c_stock;
                if (sel_valid) begin
                    e_err = 1; e_ec = 3;
                end else if (coin_ok) begin
                    m_credit += int'(coin_value); m_session = 1; m_idle = 0;
                end
            end else if (cancel) begin
                start_refund();
            end else if (sel_valid) begin
                m_sel = int'(product_sel);
                if (m_sel == 3) m_ec = 1;
                else if (m_cnt[m_sel] == 0) m_ec = 2;
                else if (m_credit < price(m_sel)) m_ec = 3;
                else m_ec = 0;
                m_ph = (m_ec != 0) ? 2 : 3;
                m_t0 = m_cyc;
            end else if (coin_ok) begin
                m_credit += int'(coin_value); m_idle = 0;
            end else if (m_idle == c_timeout - 1) begin
                start_refund();
            end else begin
                m_idle++;
            end
        end
        e_busy = (m_ph != 0);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, m_cyc, act, exp);
        end
    endtask

    task automatic compare_all();
        chk("dispense", int'(dispense), int'(e_disp));
        if (e_disp) chk("dispensed_sel", int'(dispensed_sel), e_dsel);
        chk("change_valid", int'(change_valid), int'(e_cv));
        if (e_cv) chk("change", int'(change), e_chg);
        chk("credit", int'(credit), m_credit);
        chk("prod1_count", int'(prod1_count), m_cnt[0]);
        chk("prod2_count", int'(prod2_count), m_cnt[1]);
        chk("prod3_count", int'(prod3_count), m_cnt[2]);
        chk("coin_reject", int'(coin_reject), int'(e_rej));
        chk("err", int'(err), int'(e_err));
        if (e_err) chk("err_code", int'(err_code), e_ec);
        chk("busy", int'(busy), int'(e_busy));
    endtask

    task automatic step(input bit r, input bit cv, input int cval, input bit sv,
                        input int ps, input bit cn, input bit rs);
        @(negedge clk);
        rst = r; coin_valid = cv; coin_value = 6'(cval); sel_valid = sv;
        product_sel = 2'(ps); cancel = cn; restock = rs;
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic idle();           step(0, 0, 0, 0, 0, 0, 0); endtask
    task automatic coin(input int v); step(0, 1, v, 0, 0, 0, 0); endtask
    task automatic sel(input int p);  step(0, 0, 0, 1, p, 0, 0); endtask

    initial begin
        int cv_list [10] = '{0, 5, 10, 15, 20, 25, 30, 40, 50, 63};
        rst = 1; coin_valid = 0; coin_value = 0; sel_valid = 0;
        product_sel = 0; cancel = 0; restock = 0;
        for (int i = 0; i < 3; i++) m_cnt[i] = c_stock;

        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        chk("rst_prod1", int'(prod1_count), 9);
        chk("rst_credit", int'(credit), 0);

        coin(10); sel(0); idle();
        chk("buy0_dispense", int'(dispense), 1);
        chk("buy0_dsel", int'(dispensed_sel), 0);
        idle();
        chk("buy0_count", int'(prod1_count), 8);
        chk("buy0_credit", int'(credit), 0);
        chk("buy0_no_change", int'(change_valid), 0);

        coin(30); sel(1); idle();
        chk("buy1_dispense", int'(dispense), 1);
        idle();
        chk("buy1_change_valid", int'(change_valid), 1);
        chk("buy1_change", int'(change), 10);
        chk("buy1_count", int'(prod2_count), 8);
        idle();
        chk("buy1_credit", int'(credit), 0);

        coin(30); sel(2); idle();
        chk("short_err", int'(err), 1);
        chk("short_err_code", int'(err_code), 3);
        chk("short_credit", int'(credit), 30);
        coin(15); sel(2); idle();
        chk("buy2_dispense", int'(dispense), 1);
        idle();
        chk("buy2_change", int'(change), 5);
        idle();

        for (int i = 0; i < 8; i++) begin
            coin(10); sel(0); idle(); idle();
        end
        chk("drain_count", int'(prod1_count), 0);
        coin(10); sel(0); idle();
        chk("soldout_err_code", int'(err_code), 2);
        chk("soldout_credit", int'(credit), 10);
        step(0, 0, 0, 0, 0, 1, 0);
        chk("cancel_change", int'(change), 10);
        idle();
        step(0, 0, 0, 0, 0, 0, 1);
        chk("restock_prod1", int'(prod1_count), 9);
        chk("restock_prod3", int'(prod3_count), 9);

        coin(40); coin(30);
        chk("overflow_reject", int'(coin_reject), 1);
        chk("overflow_credit", int'(credit), 40);
        repeat (14) idle();
        chk("timeout_early", int'(change_valid), 0);
        idle();
        chk("timeout_refund", int'(change_valid), 1);
        chk("timeout_change", int'(change), 40);
        idle();

        coin(10); step(0, 1, 5, 1, 0, 0, 0);
        chk("coin_sel_reject", int'(coin_reject), 1);
        idle();
        chk("coin_sel_dispense", int'(dispense), 1);
        idle();
        coin(10); sel(3); idle();
        chk("invalid_err_code", int'(err_code), 1);
        step(0, 0, 0, 0, 0, 1, 0); idle();

        coin(10); sel(0); idle();
        chk("pre_rst_dispense", int'(dispense), 1);
        step(1, 0, 0, 0, 0, 0, 0);
        chk("mid_rst_dispense", int'(dispense), 0);
        chk("mid_rst_prod1", int'(prod1_count), 9);
        chk("mid_rst_change_valid", int'(change_valid), 0);

        for (int n = 0; n < c_rand_cycs; n++) begin
            step(($urandom_range(0, 299) == 0),
                 ($urandom_range(0, 2) == 0),
                 cv_list[$urandom_range(0, 9)],
                 ($urandom_range(0, 5) == 0),
                 int'($urandom_range(0, 3)),
                 ($urandom_range(0, 24) == 0),
                 ($urandom_range(0, 14) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
